mem_access: RTL

Memory-stage load/store unit of the pipelined RISC-V core. It sits between the execute/memory pipeline register and the memory/writeback register: it consumes the M-stage address, store data and access controls, and produces the `ReadDataM` value that the writeback register captures. It runs a variable-latency req/ack transaction on the data-memory bus, stalls the pipeline while a transaction is outstanding, and handles byte-lane steering, load sign/zero extension, alignment rejection and bus timeout.

---
 rtl/mem_access.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Memory-stage load/store unit: req/ack bus master with lane steering, load formatting,
// alignment rejection and bus timeout.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] AluResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        RejectM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;

  logic        access;
  logic        legal;
  logic        aligned;
  logic        accepted;
  logic        in_idle;
  logic        in_busy;
  logic        expired;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] shifted;
  logic [31:0] load_fmt;

  assign access  = MemReadM | MemWriteM;
  assign in_idle = (state == IDLE);
  assign in_busy = (state == BUSY);
  assign expired = (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    legal = 1'b0;
    if (MemWriteM) begin
      legal = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010);
    end else begin
      legal = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010) ||
              (Funct3M == 3'b100) || (Funct3M == 3'b101);
    end
  end

  always_comb begin
    aligned = 1'b1;
    be_c    = 4'b1111;
    wdata_c = WriteDataM;
    case (Funct3M[1:0])
      2'b00: begin
        be_c    = 4'b0001 << AluResultM[1:0];
        wdata_c = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        aligned = ~AluResultM[0];
        be_c    = 4'b0011 << AluResultM[1:0];
        wdata_c = {2{WriteDataM[15:0]}};
      end
      default: aligned = (AluResultM[1:0] == 2'b00);
    endcase
  end

  assign accepted = access & legal & aligned;
  assign RejectM  = in_idle & access & ~accepted;
  assign StallM   = (in_idle & accepted) | in_busy;

  // Formatting uses the size/offset captured at launch, since M inputs may not be trusted later.
  always_comb begin
    shifted  = mem_rdata >> {lo_q, 3'b000};
    load_fmt = mem_rdata;
    case (f3_q)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_fmt = {24'd0, shifted[7:0]};
      3'b101:  load_fmt = {16'd0, shifted[15:0]};
      default: load_fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      f3_q      <= 3'd0;
      lo_q      <= 2'd0;
      ReadDataM <= 32'd0;
      BusErrM   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          BusErrM <= 1'b0;
          if (accepted) begin
            state     <= BUSY;
            cnt       <= 8'd0;
            f3_q      <= Funct3M;
            lo_q      <= AluResultM[1:0];
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {AluResultM[31:2], 2'b00};
            mem_be    <= be_c;
            mem_wdata <= wdata_c;
          end
        end
        BUSY: begin
          if (mem_ack || expired) begin
            state     <= DONE;
            BusErrM   <= ~mem_ack;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            if (!mem_ack) begin
              ReadDataM <= 32'd0;
            end else if (!mem_we) begin
              ReadDataM <= load_fmt;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          BusErrM <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          BusErrM <= 1'b0;
        end
      endcase
    end
  end

endmodule
